// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder-sharing arbiter.
// Optional subtract support is enabled with the ADDER_ARB_SUB_EN macro.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_N          = 32;
  localparam int DEF_ADD_CYCLES = 2;
  localparam int CNT_W          = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// Combinational round-robin select: search starts one past last_grant and wraps,
// giving a one-hot grant plus the matching binary index.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = IDW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external combinational adder among NREQ requesters in round-robin order.
// Define ADDER_ARB_SUB_EN to add the per-requester req_sub (A - B) input.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int N          = DEF_N,
  parameter int ADD_CYCLES = DEF_ADD_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*N-1:0]           req_a,
  input  logic [NREQ*N-1:0]           req_b,
  input  logic [NREQ-1:0]             req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NREQ-1:0]             req_sub,
`endif
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic [N-1:0]                rsp_sum,
  output logic                        rsp_cout,
  output logic [N-1:0]                add_a,
  output logic [N-1:0]                add_b,
  output logic                        add_cin,
  input  logic [N-1:0]                add_sum,
  input  logic                        add_cout
);

  localparam int IDW = id_width(NREQ);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   last_grant;
  logic [N-1:0]     op_a_reg;
  logic [N-1:0]     op_b_reg;
  logic             op_cin_reg;
  logic             op_sub_reg;

  logic [NREQ-1:0]  pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  logic [N-1:0]     a_arr [NREQ];
  logic [N-1:0]     b_arr [NREQ];
  logic [NREQ-1:0]  sub_vec;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*N +: N];
    assign b_arr[gi] = req_b[gi*N +: N];
  end

`ifdef ADDER_ARB_SUB_EN
  assign sub_vec = req_sub;
`else
  assign sub_vec = '0;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Held low while in reset so nothing looks accepted during an abort.
  assign req_ready = (state == IDLE && rst_n) ? pick_grant : '0;

  // Subtraction is A + ~B + 1; the stored B stays untouched.
  assign add_a   = op_a_reg;
  assign add_b   = op_sub_reg ? ~op_b_reg : op_b_reg;
  assign add_cin = op_sub_reg ? 1'b1 : op_cin_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDW'(NREQ - 1);
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_cin_reg <= 1'b0;
      op_sub_reg <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_a_reg   <= a_arr[pick_idx];
            op_b_reg   <= b_arr[pick_idx];
            op_cin_reg <= req_cin[pick_idx];
            op_sub_reg <= sub_vec[pick_idx];
            last_grant <= pick_idx;
            cnt        <= CNT_W'(ADD_CYCLES - 1);
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == '0) begin
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= last_grant;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a transaction-level reference model.
// Subtract vectors run only when ADDER_ARB_SUB_EN is defined.
module tb_adder_share_arbiter;

  localparam int NREQ       = 4;
  localparam int N          = 32;
  localparam int ADD_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic              add_cin;
  logic [N-1:0]      add_sum;
  logic              add_cout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(
    .NREQ       (NREQ),
    .N          (N),
    .ADD_CYCLES (ADD_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // The shared adder that lives outside the block.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int           m_last;
  int           m_cnt;
  bit           m_pending;
  int           m_id;
  logic [N-1:0] m_sum;
  logic         m_cout;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    logic [N:0]   full;
    logic [N-1:0] b_eff;
    logic         c_eff;
    if (!rst_n) begin
      m_last    = NREQ - 1;
      m_cnt     = 0;
      m_pending = 0;
    end else if (m_pending) begin
      if (rsp_ready) m_pending = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_pending = 1;
    end else begin
      w = pick(req_valid, m_last);
      if (w >= 0) begin
`ifdef ADDER_ARB_SUB_EN
        b_eff = req_sub[w] ? ~req_b[w*N +: N] : req_b[w*N +: N];
        c_eff = req_sub[w] ? 1'b1 : req_cin[w];
`else
        b_eff = req_b[w*N +: N];
        c_eff = req_cin[w];
`endif
        full   = {1'b0, req_a[w*N +: N]} + {1'b0, b_eff} + {{N{1'b0}}, c_eff};
        m_sum  = full[N-1:0];
        m_cout = full[N];
        m_id   = w;
        m_last = w;
        m_cnt  = ADD_CYCLES;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int w;
    if (rst_n) begin
      exp_ready = '0;
      w = pick(req_valid, m_last);
      if (!m_pending && m_cnt == 0 && w >= 0) exp_ready[w] = 1'b1;
      chk("model_req_ready", 64'(req_ready), 64'(exp_ready));
      chk("model_rsp_valid", 64'(rsp_valid), 64'(m_pending));
      if (m_pending) begin
        chk("model_rsp_id",   64'(rsp_id),   64'(m_id));
        chk("model_rsp_sum",  64'(rsp_sum),  64'(m_sum));
        chk("model_rsp_cout", 64'(rsp_cout), 64'(m_cout));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic send(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic sub, output int lat);
    int k;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_cin[id]      = cin;
    req_sub[id]      = sub;
    req_valid[id]    = 1'b1;
    #1;
    k = 0;
    while (!req_ready[id] && k < 40) begin
      tick();
      #1;
      k++;
    end
    if (!req_ready[id]) chk("accept_timeout", 64'(req_ready[id]), 64'd1);
    tick();
    req_valid[id] = 1'b0;
    wait_rsp(lat);
    $display("txn id=%0d a=%h b=%h cin=%0d sub=%0d -> id=%0d sum=%h cout=%0d lat=%0d",
             id, a, b, cin, sub, rsp_id, rsp_sum, rsp_cout, lat);
  endtask

  initial begin
    int lat;
    int n;
    int order[5];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    req_cin = '0; req_sub = '0; rsp_ready = 1'b1;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);
    chk("reset_add_a",     64'(add_a),     64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 1.
    req_valid[1] = 1'b1;
    #1;
    chk("t1_ready_onehot", 64'(req_ready), 64'b0010);
    send(1, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, lat);
    chk("t1_latency", 64'(lat), 64'(ADD_CYCLES));
    chk("t1_sum",  64'(rsp_sum),  64'h9);
    chk("t1_cout", 64'(rsp_cout), 64'd0);
    chk("t1_id",   64'(rsp_id),   64'd1);

    // Overflow wraps and reports carry-out.
    send(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("t2_sum",  64'(rsp_sum),  64'h0);
    chk("t2_cout", 64'(rsp_cout), 64'd1);
    chk("t2_id",   64'(rsp_id),   64'd2);

    // All requesters valid continuously from reset.
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'h1111_1111 * (i + 1);
      req_b[i*N +: N] = 32'h0F0F_0F0F;
      req_cin[i]      = 1'(i);
      req_sub[i]      = 1'b0;
    end
    req_valid = '1;
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_rsp(n);
      order[j] = int'(rsp_id);
      $display("txn rotation j=%0d id=%0d sum=%h cout=%0d", j, rsp_id, rsp_sum, rsp_cout);
      chk("t3_order", 64'(order[j]), 64'(exp_order[j]));
      if (j > 0) chk("t3_period", 64'(n + 1), 64'(ADD_CYCLES + 2));
      if (j == 0) chk("t3_sum0", 64'(rsp_sum), 64'h2020_2020);
      tick();
    end

    // Back-pressure: hold the response for 10 cycles.
    rsp_ready = 1'b0;
    wait_rsp(n);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("t4_hold_sum",   64'(rsp_sum),   64'h3131_3132);
      chk("t4_hold_id",    64'(rsp_id),    64'd1);
      chk("t4_hold_ready", 64'(req_ready), 64'd0);
    end
    $display("txn backpressure id=%0d sum=%h held 10 cycles", rsp_id, rsp_sum);
    rsp_ready = 1'b1;
    tick();
    chk("t4_next_grant", 64'(req_ready), 64'b0100);

    // Abort during ISSUE.
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_req_ready", 64'(req_ready), 64'd0);
    chk("t5_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("t5_rsp_id",    64'(rsp_id),    64'd0);
    chk("t5_add_a",     64'(add_a),     64'd0);
    tick(); tick();
    chk("t5_still_idle", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("t5_first_grant", 64'(req_ready), 64'b0001);
    $display("txn abort: outputs back to reset, first grant restored");
    req_valid = '0;
    tick(); tick();

`ifdef ADDER_ARB_SUB_EN
    send(0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, lat);
    chk("sub_borrow_sum",  64'(rsp_sum),  64'hFFFF_FFF0);
    chk("sub_borrow_cout", 64'(rsp_cout), 64'd0);
    send(3, 32'h0000_0020, 32'h0000_0010, 1'b0, 1'b1, lat);
    chk("sub_sum",  64'(rsp_sum),  64'h10);
    chk("sub_cout", 64'(rsp_cout), 64'd1);
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
